// File: rtl/multi_ch_dma_ctrl.sv
// Command/DMA controller: loads weight pages into NUM_CH engine channels, streams
// image pages to the image consumer and writes result pages back to memory.
module multi_ch_dma_ctrl #(
  parameter int ADDR_W        = 28,
  parameter int DATA_W        = 512,
  parameter int NUM_CH        = 2,
  parameter int CH_W          = 1,
  parameter int PAGES_PER_IMG = 1407,
  parameter int RES_PER_IMG   = 3,
  parameter int CNT_W         = 16,
  parameter int IDX_W         = (PAGES_PER_IMG > 1) ? $clog2(PAGES_PER_IMG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_wr_en,
  input  logic [1:0]        reg_sel,
  input  logic [ADDR_W-1:0] reg_databus,
  input  logic              cmd_vld,
  input  logic              cmd_op,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_len,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic              busy,
  output logic              read_request_valid,
  output logic              write_request_valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] read_data,
  input  logic              write_done,
  input  logic [NUM_CH-1:0] wt_req,
  output logic [NUM_CH-1:0] wt_vld,
  output logic [DATA_W-1:0] wt_data,
  input  logic [NUM_CH-1:0] wt_done,
  input  logic              img_rdy,
  output logic              img_vld,
  output logic [DATA_W-1:0] img_data,
  output logic [IDX_W-1:0]  img_idx,
  output logic              img_last,
  input  logic              res_vld,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_rdy
);

  localparam int RES_W = (RES_PER_IMG > 1) ? $clog2(RES_PER_IMG + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, WT_REQ, WT_WAIT, IMG_ARB, IMG_REQ, IMG_WAIT, RES_WAIT, WR_WAIT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] img_addr, rslt_addr, wt_addr;
  logic [CNT_W-1:0]  img_cnt, wt_rem;
  logic [CH_W-1:0]   ch;
  logic [IDX_W-1:0]  page;
  logic [RES_W-1:0]  res_cnt;
  logic              err_flag;

  logic              ch_ok, sel_req, sel_done, last_page, res_last, wt_last;
  logic [NUM_CH-1:0] ch_onehot;

  assign ch_ok     = (32'(cmd_ch) < NUM_CH);
  assign last_page = (page == IDX_W'(PAGES_PER_IMG - 1));
  assign res_last  = (res_cnt == RES_W'(RES_PER_IMG - 1));
  assign wt_last   = (wt_rem == CNT_W'(1));
  assign busy      = (state != IDLE);

  // Channel select done by loop so the index never exceeds the NUM_CH range.
  always_comb begin
    sel_req   = 1'b0;
    sel_done  = 1'b0;
    ch_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(ch) == i) begin
        sel_req      = wt_req[i];
        sel_done     = wt_done[i];
        ch_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_vld) begin
          if (cmd_op == 1'b0) begin
            if (!ch_ok || cmd_len == '0) state_nxt = DONE;
            else                         state_nxt = WT_REQ;
          end else begin
            if (img_cnt == '0) state_nxt = DONE;
            else               state_nxt = IMG_ARB;
          end
        end
      end
      WT_REQ: begin
        if (sel_done)     state_nxt = DONE;
        else if (sel_req) state_nxt = WT_WAIT;
      end
      WT_WAIT:  if (data_valid) state_nxt = wt_last ? DONE : WT_REQ;
      IMG_ARB:  if (img_rdy) state_nxt = IMG_REQ;
      IMG_REQ:  state_nxt = IMG_WAIT;
      IMG_WAIT: if (data_valid) state_nxt = last_page ? RES_WAIT : IMG_REQ;
      RES_WAIT: if (res_vld) state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (write_done) begin
          if (!res_last)                  state_nxt = RES_WAIT;
          else if (img_cnt == CNT_W'(1))  state_nxt = DONE;
          else                            state_nxt = IMG_ARB;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Requests are registered: a data_valid in the request cycle is seen by the WAIT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_addr            <= '0;
      rslt_addr           <= '0;
      wt_addr             <= '0;
      img_cnt             <= '0;
      wt_rem              <= '0;
      ch                  <= '0;
      page                <= '0;
      res_cnt             <= '0;
      err_flag            <= 1'b0;
      cmd_done            <= 1'b0;
      cmd_err             <= 1'b0;
      read_request_valid  <= 1'b0;
      write_request_valid <= 1'b0;
      address             <= '0;
      write_data          <= '0;
      wt_vld              <= '0;
      wt_data             <= '0;
      img_vld             <= 1'b0;
      img_data            <= '0;
      img_idx             <= '0;
      img_last            <= 1'b0;
      res_rdy             <= 1'b0;
    end else begin
      cmd_done            <= 1'b0;
      cmd_err             <= 1'b0;
      read_request_valid  <= 1'b0;
      write_request_valid <= 1'b0;
      wt_vld              <= '0;
      img_vld             <= 1'b0;
      img_last            <= 1'b0;
      res_rdy             <= 1'b0;
      case (state)
        IDLE: begin
          if (reg_wr_en) begin
            case (reg_sel)
              2'd0:    img_addr  <= reg_databus;
              2'd1:    img_cnt   <= reg_databus[CNT_W-1:0];
              2'd2:    rslt_addr <= reg_databus;
              default: ;
            endcase
          end
          if (cmd_vld) begin
            err_flag <= (cmd_op == 1'b0) && !ch_ok;
            if (cmd_op == 1'b0) begin
              ch      <= cmd_ch;
              wt_addr <= cmd_addr;
              wt_rem  <= cmd_len;
            end
          end
        end
        WT_REQ: begin
          if (!sel_done && sel_req) begin
            read_request_valid <= 1'b1;
            address            <= wt_addr;
          end
        end
        WT_WAIT: begin
          if (data_valid) begin
            wt_vld  <= ch_onehot;
            wt_data <= read_data;
            wt_addr <= wt_addr + 1'b1;
            wt_rem  <= wt_rem - 1'b1;
          end
        end
        IMG_ARB: if (img_rdy) page <= '0;
        IMG_REQ: begin
          read_request_valid <= 1'b1;
          address            <= img_addr;
        end
        IMG_WAIT: begin
          if (data_valid) begin
            img_vld  <= 1'b1;
            img_data <= read_data;
            img_idx  <= page;
            img_last <= last_page;
            img_addr <= img_addr + 1'b1;
            if (last_page) res_cnt <= '0;
            else           page    <= page + 1'b1;
          end
        end
        RES_WAIT: begin
          if (res_vld) begin
            write_data          <= res_data;
            res_rdy             <= 1'b1;
            write_request_valid <= 1'b1;
            address             <= rslt_addr;
          end
        end
        WR_WAIT: begin
          if (write_done) begin
            rslt_addr <= rslt_addr + 1'b1;
            res_cnt   <= res_cnt + 1'b1;
            if (res_last) img_cnt <= img_cnt - 1'b1;
          end
        end
        DONE: begin
          cmd_done <= 1'b1;
          cmd_err  <= err_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ch_dma_ctrl.sv
// Directed bench for multi_ch_dma_ctrl: memory/result responders, a negedge monitor
// feeding observation queues, and hand-computed expected queues per step.
module tb_multi_ch_dma_ctrl;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int PAGES  = 4;
  localparam int RES    = 3;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 2;

  typedef logic [63:0] q64_t[$];

  logic              clk, rst_n;
  logic              reg_wr_en;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] reg_databus;
  logic              cmd_vld, cmd_op;
  logic [CH_W-1:0]   cmd_ch;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_len;
  logic              cmd_done, cmd_err, busy;
  logic              read_request_valid, write_request_valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data, read_data, wt_data, img_data, res_data;
  logic              data_valid, write_done;
  logic [NUM_CH-1:0] wt_req, wt_vld, wt_done;
  logic              img_rdy, img_vld, img_last, res_vld, res_rdy;
  logic [IDX_W-1:0]  img_idx;

  int n_checks = 0;
  int n_err    = 0;
  int rd_lat   = 2;
  int wr_lat   = 1;
  logic res_en = 1'b0;

  q64_t obs_rd_q, obs_wr_q, obs_wd_q, obs_wt_q, obs_img_q;
  logic [63:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, rdy_cnt = 0;

  multi_ch_dma_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
    .PAGES_PER_IMG(PAGES), .RES_PER_IMG(RES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr_en(reg_wr_en), .reg_sel(reg_sel),
    .reg_databus(reg_databus), .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .busy(busy), .read_request_valid(read_request_valid),
    .write_request_valid(write_request_valid), .address(address),
    .write_data(write_data), .data_valid(data_valid), .read_data(read_data),
    .write_done(write_done), .wt_req(wt_req), .wt_vld(wt_vld), .wt_data(wt_data),
    .wt_done(wt_done), .img_rdy(img_rdy), .img_vld(img_vld), .img_data(img_data),
    .img_idx(img_idx), .img_last(img_last), .res_vld(res_vld), .res_data(res_data),
    .res_rdy(res_rdy)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {4'hD, a};
  endfunction

  // Memory responder: read data after rd_lat negedges (0 = same cycle as the request)
  initial begin
    logic [ADDR_W-1:0] a;
    data_valid = 1'b0;
    write_done = 1'b0;
    read_data  = '0;
    forever begin
      @(negedge clk);
      data_valid = 1'b0;
      write_done = 1'b0;
      if (read_request_valid) begin
        a = address;
        repeat (rd_lat) @(negedge clk);
        read_data  = mem_word(a);
        data_valid = 1'b1;
      end else if (write_request_valid) begin
        repeat (wr_lat) @(negedge clk);
        write_done = 1'b1;
      end
    end
  end

  // Result producer: offers a new page after each acceptance
  initial begin
    res_data = 32'h5000_0000;
    res_vld  = 1'b0;
    forever begin
      @(negedge clk);
      if (res_rdy) res_data = res_data + 1;
      res_vld = res_en;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_request_valid) obs_rd_q.push_back(64'(address));
      if (write_request_valid) begin
        obs_wr_q.push_back(64'(address));
        obs_wd_q.push_back(64'(write_data));
      end
      if (wt_vld != '0) obs_wt_q.push_back(64'({wt_vld, wt_data}));
      if (img_vld) obs_img_q.push_back(64'({img_last, img_idx, img_data}));
      if (cmd_done) done_cnt++;
      if (cmd_err) err_cnt++;
      if (res_rdy) rdy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_list(input string tag, input q64_t got, input int base);
    chk($sformatf("%s_count", tag), 64'(got.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size()) chk($sformatf("%s[%0d]", tag, i), got[base + i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [ADDR_W-1:0] d);
    reg_sel     = sel;
    reg_databus = d;
    reg_wr_en   = 1'b1;
    @(negedge clk);
    reg_wr_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic op, input logic [CH_W-1:0] c,
                          input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] len);
    cmd_op   = op;
    cmd_ch   = c;
    cmd_addr = a;
    cmd_len  = len;
    cmd_vld  = 1'b1;
    @(negedge clk);
    cmd_vld  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (cmd_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(cmd_done), 64'd1);
  endtask

  initial begin
    int rb, wb, tb, ib, wdb, db, eb, yb, n, cyc;
    rst_n = 1'b0; reg_wr_en = 1'b0; reg_sel = '0; reg_databus = '0;
    cmd_vld = 1'b0; cmd_op = 1'b0; cmd_ch = '0; cmd_addr = '0; cmd_len = '0;
    wt_req = '0; wt_done = '0; img_rdy = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_done", 64'({cmd_done, cmd_err}), 64'd0);
    chk("rst_req", 64'({read_request_valid, write_request_valid}), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_strobes", 64'({wt_vld, img_vld, img_last, res_rdy, img_idx}), 64'd0);
    chk("rst_data", 64'({write_data, wt_data}), 64'd0);

    // LOAD_WEIGHTS ch=1 addr=0x100 len=3, data 2 cycles after each request
    wt_req = 2'b11; rd_lat = 2;
    rb = obs_rd_q.size(); tb = obs_wt_q.size(); db = done_cnt; eb = err_cnt;
    send_cmd(1'b0, 2'd1, 28'h100, 16'd3);
    wait_done("t1_done", 200);
    tick(2);
    for (int k = 0; k < 3; k++) exp_q.push_back(64'(28'h100 + k));
    compare_list("t1_rd", obs_rd_q, rb);
    for (int k = 0; k < 3; k++) exp_q.push_back(64'({2'b10, mem_word(28'h100 + k)}));
    compare_list("t1_wt", obs_wt_q, tb);
    chk("t1_done_cnt", 64'(done_cnt - db), 64'd1);
    chk("t1_err_cnt", 64'(err_cnt - eb), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Same-cycle data return and address wrap on channel 0
    rd_lat = 0;
    rb = obs_rd_q.size(); tb = obs_wt_q.size();
    send_cmd(1'b0, 2'd0, 28'hFFF_FFFF, 16'd2);
    wait_done("t1b_done", 200);
    tick(2);
    exp_q.push_back(64'(28'hFFF_FFFF));
    exp_q.push_back(64'(28'h000_0000));
    compare_list("t1b_rd", obs_rd_q, rb);
    exp_q.push_back(64'({2'b01, mem_word(28'hFFF_FFFF)}));
    exp_q.push_back(64'({2'b01, mem_word(28'h000_0000)}));
    compare_list("t1b_wt", obs_wt_q, tb);

    // Illegal channel: done+err two cycles after cmd_vld, no memory traffic
    rb = obs_rd_q.size();
    send_cmd(1'b0, 2'd3, 28'h500, 16'd4);
    chk("t2_busy_mid", 64'(busy), 64'd1);
    chk("t2_done_early", 64'(cmd_done), 64'd0);
    tick(1);
    chk("t2_done_err", 64'({cmd_done, cmd_err}), 64'b11);
    chk("t2_busy_after", 64'(busy), 64'd0);
    tick(3);
    chk("t2_no_rd", 64'(obs_rd_q.size() - rb), 64'd0);

    // Zero-length load completes without error or traffic
    rb = obs_rd_q.size();
    send_cmd(1'b0, 2'd0, 28'h600, 16'd0);
    tick(1);
    chk("t3_done_err", 64'({cmd_done, cmd_err}), 64'b10);
    tick(3);
    chk("t3_no_rd", 64'(obs_rd_q.size() - rb), 64'd0);

    // PROCESS: 2 images of 4 pages, 3 results each
    reg_write(2'd0, 28'h200);
    reg_write(2'd1, 28'd2);
    reg_write(2'd2, 28'h900);
    img_rdy = 1'b1; res_en = 1'b1; rd_lat = 1; wr_lat = 1;
    rb = obs_rd_q.size(); ib = obs_img_q.size(); wb = obs_wr_q.size();
    wdb = obs_wd_q.size(); db = done_cnt; yb = rdy_cnt;
    send_cmd(1'b1, 2'd0, '0, '0);
    wait_done("t4_done", 1000);
    tick(2);
    for (int k = 0; k < 8; k++) exp_q.push_back(64'(28'h200 + k));
    compare_list("t4_rd", obs_rd_q, rb);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(64'({(k % 4) == 3, 2'(k % 4), mem_word(28'h200 + k)}));
    compare_list("t4_img", obs_img_q, ib);
    for (int k = 0; k < 6; k++) exp_q.push_back(64'(28'h900 + k));
    compare_list("t4_wr", obs_wr_q, wb);
    for (int k = 0; k < 6; k++) exp_q.push_back(64'(32'h5000_0000 + k));
    compare_list("t4_wdata", obs_wd_q, wdb);
    chk("t4_res_rdy_cnt", 64'(rdy_cnt - yb), 64'd6);
    chk("t4_done_cnt", 64'(done_cnt - db), 64'd1);

    // img_cnt is now 0; a config write while busy must be dropped
    rb = obs_rd_q.size();
    send_cmd(1'b1, 2'd0, '0, '0);
    reg_write(2'd1, 28'd5);
    chk("t5_done", 64'(cmd_done), 64'd1);
    send_cmd(1'b1, 2'd0, '0, '0);
    tick(1);
    chk("t5_cnt_kept", 64'(cmd_done), 64'd1);
    tick(5);
    chk("t5_no_rd", 64'(obs_rd_q.size() - rb), 64'd0);

    // Early termination via wt_done after the second page
    rd_lat = 1; wt_req = 2'b11; wt_done = 2'b00;
    rb = obs_rd_q.size(); tb = obs_wt_q.size(); db = done_cnt;
    send_cmd(1'b0, 2'd0, 28'h300, 16'd5);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wt_vld[0]) n++;
    end
    wt_done = 2'b01;
    chk("t6_two_pulses_seen", 64'(n), 64'd2);
    wait_done("t6_done", 100);
    wt_done = 2'b00;
    tick(3);
    exp_q.push_back(64'(28'h300));
    exp_q.push_back(64'(28'h301));
    compare_list("t6_rd", obs_rd_q, rb);
    exp_q.push_back(64'({2'b01, mem_word(28'h300)}));
    exp_q.push_back(64'({2'b01, mem_word(28'h301)}));
    compare_list("t6_wt", obs_wt_q, tb);
    chk("t6_done_cnt", 64'(done_cnt - db), 64'd1);

    // Reset while waiting for image data, then restart from cleared registers
    reg_write(2'd0, 28'h400);
    reg_write(2'd1, 28'd1);
    rd_lat = 6;
    send_cmd(1'b1, 2'd0, '0, '0);
    cyc = 0;
    while (!read_request_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t7_req_seen", 64'(read_request_valid), 64'd1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_strobes",
        64'({cmd_done, cmd_err, read_request_valid, write_request_valid,
             img_vld, img_last, res_rdy, wt_vld}), 64'd0);
    chk("t7_rst_address", 64'(address), 64'd0);
    tick(10);
    db = done_cnt;
    rst_n = 1'b1;
    tick(2);
    chk("t7_no_done", 64'(done_cnt - db), 64'd0);
    rd_lat = 1;
    rb = obs_rd_q.size(); wb = obs_wr_q.size();
    reg_write(2'd1, 28'd1);
    send_cmd(1'b1, 2'd0, '0, '0);
    wait_done("t7_restart_done", 500);
    tick(2);
    for (int k = 0; k < 4; k++) exp_q.push_back(64'(k));
    compare_list("t7_rd", obs_rd_q, rb);
    for (int k = 0; k < 3; k++) exp_q.push_back(64'(k));
    compare_list("t7_wr", obs_wr_q, wb);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
